// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU control-step sequencer: step encoding,
// opcode values, IR field positions and the opcode classifier.
package alu_ctrl_pkg;

    localparam int IR_OP_MSB  = 31;
    localparam int IR_OP_W    = 5;
    localparam int IR_RA_LSB  = 23;
    localparam int IR_RB_LSB  = 19;
    localparam int IR_RC_LSB  = 15;
    localparam int REG_IDX_W  = 4;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        ERR  = 4'd8
    } state_e;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00011,
        OP_SUB  = 5'b00100,
        OP_AND  = 5'b00101,
        OP_OR   = 5'b00110,
        OP_ROR  = 5'b00111,
        OP_ROL  = 5'b01000,
        OP_SHR  = 5'b01001,
        OP_SHRA = 5'b01010,
        OP_SHL  = 5'b01011,
        OP_MUL  = 5'b01111,
        OP_DIV  = 5'b10000,
        OP_NEG  = 5'b10001,
        OP_NOT  = 5'b10010
    } opcode_e;

    typedef enum logic [1:0] {
        CLS_ILLEGAL = 2'd0,
        CLS_BINARY  = 2'd1,
        CLS_UNARY   = 2'd2,
        CLS_MULDIV  = 2'd3
    } op_class_e;

    function automatic op_class_e op_class(input logic [IR_OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  return CLS_BINARY;
            OP_NEG, OP_NOT:                   return CLS_UNARY;
            OP_MUL, OP_DIV:                   return CLS_MULDIV;
            default:                          return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/alu_control_sequencer_if.sv
// Sequencer <-> datapath bundle: go/IR/mem_ready toward the sequencer, strobes back.
// MEM_WAIT_EN adds mem_ready.
interface alu_control_sequencer_if #(
    parameter int NREGS = 16,
    parameter int OPW   = 5
);
    logic              go;
    logic [31:0]       ir;
`ifdef MEM_WAIT_EN
    logic              mem_ready;
`endif
    logic              PCout, PCin, pc_increment, MARin;
    logic              read, MDRin, MDRout;
    logic              IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
    logic [NREGS-1:0]  reg_in;
    logic [NREGS-1:0]  reg_out;
    logic [OPW-1:0]    op_code;
    logic              done;
    logic              illegal;

    modport master (
        output go, ir,
`ifdef MEM_WAIT_EN
        output mem_ready,
`endif
        input  PCout, PCin, pc_increment, MARin, read, MDRin, MDRout,
        input  IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
        input  reg_in, reg_out, op_code, done, illegal
    );

    modport slave (
        input  go, ir,
`ifdef MEM_WAIT_EN
        input  mem_ready,
`endif
        output PCout, PCin, pc_increment, MARin, read, MDRin, MDRout,
        output IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
        output reg_in, reg_out, op_code, done, illegal
    );
endinterface

// File: rtl/alu_control_sequencer_reg_sel_decoder.sv
// Register index to one-hot enable vector; all zeros when not enabled.
module reg_sel_decoder #(
    parameter int NREGS = 16
) (
    input  logic [$clog2(NREGS)-1:0] i_idx,
    input  logic                     i_en,
    output logic [NREGS-1:0]         o_onehot
);
    always_comb begin
        o_onehot = '0;
        if (i_en) o_onehot[i_idx] = 1'b1;
    end
endmodule

// File: rtl/alu_control_sequencer.sv
// Fetch/execute control-step sequencer for register-to-register ALU instructions.
// Build option MEM_WAIT_EN: T1 waits for mem_ready before advancing.
//   state | meaning
//   IDLE  | waiting for go
//   T0-T2 | fetch: PC->MAR, memory read, MDR->IR
//   T3-T6 | execute: operand Y, ALU op, Z low / Z high write-back
//   ERR   | unsupported opcode, one-cycle illegal pulse
module alu_control_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int OPW   = 5
) (
    input  logic                   i_clk,
    input  logic                   i_clr,
    alu_control_sequencer_if.slave bus
);
    logic [3:0] r_state;
    logic [3:0] w_state_nxt;
    op_class_e  w_cls;
    logic       w_t0, w_t1, w_t2, w_t3, w_t4, w_t5, w_t6;
    logic       w_muldiv, w_unary, w_t1_adv;
    logic       w_unused_ir;

    assign w_cls    = op_class(bus.ir[IR_OP_MSB -: IR_OP_W]);
    assign w_muldiv = (w_cls == CLS_MULDIV);
    assign w_unary  = (w_cls == CLS_UNARY);

`ifdef MEM_WAIT_EN
    assign w_t1_adv = bus.mem_ready;
`else
    assign w_t1_adv = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (bus.go) w_state_nxt = T0;
            T0:   w_state_nxt = T1;
            T1:   if (w_t1_adv) w_state_nxt = T2;
            T2: begin
                case (w_cls)
                    CLS_UNARY:              w_state_nxt = T4;
                    CLS_BINARY, CLS_MULDIV: w_state_nxt = T3;
                    default:                w_state_nxt = ERR;
                endcase
            end
            T3:   w_state_nxt = T4;
            T4:   w_state_nxt = T5;
            T5: begin
                if (w_muldiv)    w_state_nxt = T6;
                else if (bus.go) w_state_nxt = T0;
                else             w_state_nxt = IDLE;
            end
            T6:   w_state_nxt = bus.go ? T0 : IDLE;
            ERR:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    assign w_t0 = (r_state == T0);
    assign w_t1 = (r_state == T1);
    assign w_t2 = (r_state == T2);
    assign w_t3 = (r_state == T3);
    assign w_t4 = (r_state == T4);
    assign w_t5 = (r_state == T5);
    assign w_t6 = (r_state == T6);

    assign bus.PCout        = w_t0;
    assign bus.pc_increment = w_t0;
    assign bus.MARin        = w_t0;
    assign bus.PCin         = w_t1;
    assign bus.read         = w_t1;
    assign bus.MDRin        = w_t1;
    assign bus.MDRout       = w_t2;
    assign bus.IRin         = w_t2;
    assign bus.Yin          = w_t3;
    assign bus.Zlowin       = w_t0 | w_t4;
    assign bus.Zhighin      = w_t4;
    assign bus.Zlowout      = w_t1 | w_t5;
    assign bus.Zhighout     = w_t6;
    assign bus.HIin         = w_t6;
    assign bus.LOin         = w_t5 & w_muldiv;
    assign bus.done         = (w_t5 & ~w_muldiv) | w_t6;
    assign bus.illegal      = (r_state == ERR);
    assign bus.op_code      = w_t4 ? bus.ir[IR_OP_MSB -: OPW] : '0;

    // T4 drives Rc for binary ops but Rb for single-operand NEG/NOT
    reg_sel_decoder #(.NREGS(NREGS)) u_out_sel (
        .i_idx    ((w_t4 && !w_unary) ? bus.ir[IR_RC_LSB +: REG_IDX_W]
                                      : bus.ir[IR_RB_LSB +: REG_IDX_W]),
        .i_en     (w_t3 | w_t4),
        .o_onehot (bus.reg_out)
    );

    reg_sel_decoder #(.NREGS(NREGS)) u_in_sel (
        .i_idx    (bus.ir[IR_RA_LSB +: REG_IDX_W]),
        .i_en     (w_t5 & ~w_muldiv),
        .o_onehot (bus.reg_in)
    );

    assign w_unused_ir = ^bus.ir[IR_RC_LSB-1:0];

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer; MEM_WAIT_EN adds the mem_ready hold test.
module tb_alu_control_sequencer;
    import alu_ctrl_pkg::*;

    localparam logic [31:0] IR_SHL = 32'h5A1B_8000;
    localparam logic [31:0] IR_MUL = 32'h7818_8000;
    localparam logic [31:0] IR_NOT = 32'h92B0_0000;
    localparam logic [31:0] IR_BAD = 32'h6000_0000;
    localparam logic [31:0] IR_ADD = 32'h1878_0000;

    localparam logic [16:0] S_PCOUT    = 17'h10000;
    localparam logic [16:0] S_PCIN     = 17'h08000;
    localparam logic [16:0] S_PCINC    = 17'h04000;
    localparam logic [16:0] S_MARIN    = 17'h02000;
    localparam logic [16:0] S_READ     = 17'h01000;
    localparam logic [16:0] S_MDRIN    = 17'h00800;
    localparam logic [16:0] S_MDROUT   = 17'h00400;
    localparam logic [16:0] S_IRIN     = 17'h00200;
    localparam logic [16:0] S_YIN      = 17'h00100;
    localparam logic [16:0] S_ZLOWIN   = 17'h00080;
    localparam logic [16:0] S_ZHIGHIN  = 17'h00040;
    localparam logic [16:0] S_ZLOWOUT  = 17'h00020;
    localparam logic [16:0] S_ZHIGHOUT = 17'h00010;
    localparam logic [16:0] S_HIIN     = 17'h00008;
    localparam logic [16:0] S_LOIN     = 17'h00004;
    localparam logic [16:0] S_DONE     = 17'h00002;
    localparam logic [16:0] S_ILLEGAL  = 17'h00001;

    localparam logic [16:0] E_T0  = S_PCOUT | S_PCINC | S_MARIN | S_ZLOWIN;
    localparam logic [16:0] E_T1  = S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN;
    localparam logic [16:0] E_T2  = S_MDROUT | S_IRIN;
    localparam logic [16:0] E_T3  = S_YIN;
    localparam logic [16:0] E_T4  = S_ZLOWIN | S_ZHIGHIN;
    localparam logic [16:0] E_T5A = S_ZLOWOUT | S_DONE;
    localparam logic [16:0] E_T5M = S_ZLOWOUT | S_LOIN;
    localparam logic [16:0] E_T6  = S_ZHIGHOUT | S_HIIN | S_DONE;

    logic clk;
    logic clr;
    int   checks;
    int   failures;
    int   done_cnt;

    alu_control_sequencer_if #(.NREGS(16), .OPW(5)) sif ();

    alu_control_sequencer #(.NREGS(16), .OPW(5)) dut (
        .i_clk (clk),
        .i_clr (clr),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] strobes();
        return {sif.PCout, sif.PCin, sif.pc_increment, sif.MARin, sif.read,
                sif.MDRin, sif.MDRout, sif.IRin, sif.Yin, sif.Zlowin, sif.Zhighin,
                sif.Zlowout, sif.Zhighout, sif.HIin, sif.LOin, sif.done, sif.illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    task automatic expect_cycle(input string tag, input logic [3:0] st, input logic [16:0] strb,
                                input logic [15:0] rin, input logic [15:0] rout,
                                input logic [4:0] op);
        chk({tag, ".state"},   32'(dut.r_state), 32'(st));
        chk({tag, ".strobes"}, 32'(strobes()),   32'(strb));
        chk({tag, ".reg_in"},  32'(sif.reg_in),  32'(rin));
        chk({tag, ".reg_out"}, 32'(sif.reg_out), 32'(rout));
        chk({tag, ".op_code"}, 32'(sif.op_code), 32'(op));
    endtask

    logic [3:0] b2b_seq [13] = '{T0, T1, T2, T3, T4, T5, T0, T1, T2, T3, T4, T5, IDLE};

    initial begin
        checks   = 0;
        failures = 0;
        clr      = 1'b1;
        sif.go   = 1'b0;
        sif.ir   = '0;
`ifdef MEM_WAIT_EN
        sif.mem_ready = 1'b1;
`endif
        tick();
        expect_cycle("reset", IDLE, '0, 16'h0, 16'h0, 5'h0);
        tick();
        clr = 1'b0;
        tick();
        expect_cycle("idle_no_go", IDLE, '0, 16'h0, 16'h0, 5'h0);

        // SHL R4,R3,R7 with go pulsed
        sif.ir = IR_SHL;
        sif.go = 1'b1;
        tick();  sif.go = 1'b0;
        expect_cycle("shl.t0", T0, E_T0, 16'h0, 16'h0, 5'h0);
        tick();  expect_cycle("shl.t1", T1, E_T1, 16'h0, 16'h0, 5'h0);
        tick();  expect_cycle("shl.t2", T2, E_T2, 16'h0, 16'h0, 5'h0);
        tick();  expect_cycle("shl.t3", T3, E_T3, 16'h0, 16'h0008, 5'h0);
        tick();  expect_cycle("shl.t4", T4, E_T4, 16'h0, 16'h0080, 5'b01011);
        tick();  expect_cycle("shl.t5", T5, E_T5A, 16'h0010, 16'h0, 5'h0);
        tick();  expect_cycle("shl.idle", IDLE, '0, 16'h0, 16'h0, 5'h0);

        // MUL R3,R1 (Ra ignored)
        sif.ir = IR_MUL;
        sif.go = 1'b1;
        tick();  sif.go = 1'b0;
        expect_cycle("mul.t0", T0, E_T0, 16'h0, 16'h0, 5'h0);
        tick();  expect_cycle("mul.t1", T1, E_T1, 16'h0, 16'h0, 5'h0);
        tick();  expect_cycle("mul.t2", T2, E_T2, 16'h0, 16'h0, 5'h0);
        tick();  expect_cycle("mul.t3", T3, E_T3, 16'h0, 16'h0008, 5'h0);
        tick();  expect_cycle("mul.t4", T4, E_T4, 16'h0, 16'h0002, 5'b01111);
        tick();  expect_cycle("mul.t5", T5, E_T5M, 16'h0, 16'h0, 5'h0);
        tick();  expect_cycle("mul.t6", T6, E_T6, 16'h0, 16'h0, 5'h0);
        tick();  expect_cycle("mul.idle", IDLE, '0, 16'h0, 16'h0, 5'h0);

        // NOT R5,R6 skips T3
        sif.ir = IR_NOT;
        sif.go = 1'b1;
        tick();  sif.go = 1'b0;
        tick();
        tick();  expect_cycle("not.t2", T2, E_T2, 16'h0, 16'h0, 5'h0);
        tick();  expect_cycle("not.t4", T4, E_T4, 16'h0, 16'h0040, 5'b10010);
        tick();  expect_cycle("not.t5", T5, E_T5A, 16'h0020, 16'h0, 5'h0);
        tick();  expect_cycle("not.idle", IDLE, '0, 16'h0, 16'h0, 5'h0);

        // ADD R0,R15,R0: destination R0 is legal
        sif.ir = IR_ADD;
        sif.go = 1'b1;
        tick();  sif.go = 1'b0;
        tick();
        tick();
        tick();  expect_cycle("add.t3", T3, E_T3, 16'h0, 16'h8000, 5'h0);
        tick();  expect_cycle("add.t4", T4, E_T4, 16'h0, 16'h0001, 5'b00011);
        tick();  expect_cycle("add.t5", T5, E_T5A, 16'h0001, 16'h0, 5'h0);
        tick();

        // unsupported opcode 01100
        sif.ir = IR_BAD;
        sif.go = 1'b1;
        tick();  sif.go = 1'b0;
        expect_cycle("bad.t0", T0, E_T0, 16'h0, 16'h0, 5'h0);
        tick();  expect_cycle("bad.t1", T1, E_T1, 16'h0, 16'h0, 5'h0);
        tick();  expect_cycle("bad.t2", T2, E_T2, 16'h0, 16'h0, 5'h0);
        tick();  expect_cycle("bad.err", ERR, S_ILLEGAL, 16'h0, 16'h0, 5'h0);
        tick();  expect_cycle("bad.idle", IDLE, '0, 16'h0, 16'h0, 5'h0);

        // two SHL back-to-back with go held
        sif.ir   = IR_SHL;
        sif.go   = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (i == 6) sif.go = 1'b0;
            chk($sformatf("b2b.state%0d", i), 32'(dut.r_state), 32'(b2b_seq[i]));
            done_cnt += int'(sif.done);
        end
        chk("b2b.done_count", 32'(done_cnt), 32'd2);

        // clr in T4 aborts, then a clean restart
        sif.go = 1'b1;
        tick();  sif.go = 1'b0;
        tick();
        tick();
        tick();
        tick();  expect_cycle("clr.t4", T4, E_T4, 16'h0, 16'h0080, 5'b01011);
        clr = 1'b1;
        tick();  clr = 1'b0;
        expect_cycle("clr.idle", IDLE, '0, 16'h0, 16'h0, 5'h0);
        tick();  expect_cycle("clr.stay", IDLE, '0, 16'h0, 16'h0, 5'h0);
        sif.go = 1'b1;
        tick();  sif.go = 1'b0;
        expect_cycle("clr.restart", T0, E_T0, 16'h0, 16'h0, 5'h0);
        repeat (6) tick();
        expect_cycle("clr.drain", IDLE, '0, 16'h0, 16'h0, 5'h0);

`ifdef MEM_WAIT_EN
        // mem_ready low for the first three T1 cycles
        sif.mem_ready = 1'b0;
        sif.go = 1'b1;
        tick();  sif.go = 1'b0;
        tick();  expect_cycle("mw.t1a", T1, E_T1, 16'h0, 16'h0, 5'h0);
        tick();  expect_cycle("mw.t1b", T1, E_T1, 16'h0, 16'h0, 5'h0);
        tick();  expect_cycle("mw.t1c", T1, E_T1, 16'h0, 16'h0, 5'h0);
        sif.mem_ready = 1'b1;
        expect_cycle("mw.t1d", T1, E_T1, 16'h0, 16'h0, 5'h0);
        tick();  expect_cycle("mw.t2", T2, E_T2, 16'h0, 16'h0, 5'h0);
        repeat (4) tick();
        expect_cycle("mw.idle", IDLE, '0, 16'h0, 16'h0, 5'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
